// File: rtl/ntt_scheduler.sv
// Address/twiddle sequencer for an in-place radix-2 forward NTT.
// Walks stages 1..LOG_N, issuing one butterfly per accepted handshake, draining the datapath between stages.
module ntt_scheduler #(
  parameter int N        = 256,
  parameter int LOG_N    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bf_ready,
  output logic             bf_valid,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-2:0] tw_idx,
  output logic [3:0]       stage,
  output logic             busy,
  output logic             done
);

  // Index arithmetic is one bit wider than an address so j+m can reach N without wrapping.
  localparam int             IW         = LOG_N + 1;
  localparam int             AW         = LOG_N;
  localparam int             TW         = LOG_N - 1;
  localparam logic [IW-1:0]  N_W        = IW'(N);
  localparam logic [3:0]     LAST_S     = 4'(LOG_N);
  localparam bit             HAS_DRAIN  = (PIPE_LAT > 0);
  localparam logic [3:0]     DRAIN_LOAD = HAS_DRAIN ? 4'(PIPE_LAT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     s_q, s_d;
  logic [AW-1:0]  k_q, k_d;
  logic [AW-1:0]  j_q, j_d;
  logic [3:0]     drain_q, drain_d;

  logic [IW-1:0]  m_cur;
  logic [IW-1:0]  half_cur;
  logic [IW-1:0]  j_step;
  logic           stage_end;

  logic [IW-1:0]  half_nxt;
  logic [3:0]     tw_shift;

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    k_d       = k_q;
    j_d       = j_q;
    drain_d   = drain_q;
    stage_end = 1'b0;

    m_cur    = IW'(1) << s_q;
    half_cur = m_cur >> 1;
    j_step   = {1'b0, j_q} + m_cur;

    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      s_d     = '0;
      k_d     = '0;
      j_d     = '0;
      drain_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ISSUE;
            s_d     = 4'd1;
            k_d     = '0;
            j_d     = '0;
          end
        end
        S_ISSUE: begin
          if (bf_ready) begin
            if (j_step < N_W) begin
              j_d = j_step[AW-1:0];
            end else if ({1'b0, k_q} != half_cur - IW'(1)) begin
              k_d = k_q + AW'(1);
              j_d = k_q + AW'(1);
            end else if (HAS_DRAIN) begin
              state_d = S_DRAIN;
              drain_d = DRAIN_LOAD;
            end else begin
              stage_end = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == 4'd0) begin
            stage_end = 1'b1;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          s_d     = '0;
        end
        default: state_d = S_IDLE;
      endcase

      // Shared by the DRAIN expiry and the zero-latency last handshake.
      if (stage_end) begin
        drain_d = '0;
        if (s_q == LAST_S) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          s_d     = s_q + 4'd1;
          k_d     = '0;
          j_d     = '0;
        end
      end
    end

    half_nxt = (IW'(1) << s_d) >> 1;
    tw_shift = LAST_S - s_d;
  end

  // Outputs are registered from the next-state values, so they align with the state register
  // and there is no combinational path from bf_ready to any output.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      s_q      <= '0;
      k_q      <= '0;
      j_q      <= '0;
      drain_q  <= '0;
      bf_valid <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      tw_idx   <= '0;
      stage    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      k_q      <= k_d;
      j_q      <= j_d;
      drain_q  <= drain_d;
      bf_valid <= (state_d == S_ISSUE);
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_DONE);
      stage    <= s_d;
      if (state_d == S_ISSUE) begin
        addr_a <= j_d;
        addr_b <= AW'({1'b0, j_d} + half_nxt);
        tw_idx <= TW'(k_d << tw_shift);
      end else begin
        addr_a <= '0;
        addr_b <= '0;
        tw_idx <= '0;
      end
    end
  end

endmodule

// File: doc/ntt_scheduler.md
NTT_SCHEDULER -- requirements
Module: ntt_scheduler

Interface
REQ-001 SHALL have parameter N, default 256: transform length, power of two, N >= 4.
REQ-002 SHALL have parameter LOG_N, default 8: log2(N).
REQ-003 SHALL have parameter PIPE_LAT, default 4: butterfly datapath read-to-writeback latency in cycles, range 0..15.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request a forward NTT; sampled in IDLE only.
REQ-007 SHALL have port abort, input, 1: cancel the transform in progress.
REQ-008 SHALL have port bf_ready, input, 1: butterfly datapath accepts the presented operation.
REQ-009 SHALL have port bf_valid, output, 1: a butterfly operation is presented.
REQ-010 SHALL have port addr_a, output, LOG_N: upper-leg coefficient index j.
REQ-011 SHALL have port addr_b, output, LOG_N: lower-leg index j + m/2.
REQ-012 SHALL have port tw_idx, output, LOG_N-1: twiddle ROM index (N/m)*k.
REQ-013 SHALL have port stage, output, 4: current stage s, 1..LOG_N; 0 when idle.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-017 SHALL move IDLE->ISSUE on start=1 and set s=1, k=0, j=0; start outside IDLE SHALL be ignored.
REQ-018 SHALL in each stage s (m=2^s, half=m/2) issue k = 0..half-1 in the outer loop, and j = k, k+m, ... < N in the inner loop, giving N/2 operations per stage.
REQ-019 SHALL drive bf_valid=1 only in ISSUE, with addr_a=j, addr_b=j+half and tw_idx=(N>>s)*k.
REQ-020 SHALL advance only on a bf_valid&&bf_ready handshake, and SHALL hold addr_a, addr_b, tw_idx and stage stable while bf_valid=1 and bf_ready=0.
REQ-021 SHALL on a handshake set j+=m; if j+m >= N, then j=k+1 and k+=1; on the last operation of the stage (k=half-1 and j+m >= N) it SHALL go to DRAIN.
REQ-022 SHALL hold DRAIN for exactly PIPE_LAT cycles with bf_valid=0; if PIPE_LAT=0, the last handshake SHALL go directly to the next stage's ISSUE, or to DONE if s=LOG_N.
REQ-023 SHALL on DRAIN expiry with s<LOG_N set s+=1, k=0, j=0 and go to ISSUE; with s=LOG_N it SHALL go to DONE.
REQ-024 SHALL assert done=1 for the single DONE cycle, then return to IDLE; start in DONE SHALL be ignored.
REQ-025 SHALL on abort=1 in any non-IDLE state go to IDLE on the next edge with no done pulse; abort SHALL have priority over a handshake in the same cycle; abort in IDLE SHALL have no effect.
REQ-026 SHALL use registered outputs only, with no combinational path from bf_ready to bf_valid or the address outputs.
REQ-027 SHALL compute all index arithmetic in LOG_N+1 bits internally, so that j+m never wraps before comparison with N.

Reset
REQ-028 SHALL on reset_n=0 at a rising edge enter IDLE with bf_valid=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, busy=0, done=0 and the drain counter at 0, regardless of state.
REQ-029 SHALL let reset mid-transform discard all progress; a new start is required afterwards.

Verification (N=8, LOG_N=3, PIPE_LAT=2)
REQ-030 SHALL verify: start at cycle 0, bf_ready=1 -> bf_valid high in cycles 1-4, 7-10 and 13-16; done=1 in cycle 19 only; busy in cycles 1-19.
REQ-031 SHALL verify the (addr_a,addr_b,tw) sequence: stage1 (0,1,0)(2,3,0)(4,5,0)(6,7,0); stage2 (0,2,0)(4,6,0)(1,3,2)(5,7,2); stage3 (0,4,0)(1,5,1)(2,6,2)(3,7,3).
REQ-032 SHALL verify: bf_ready held low 3 cycles at the second stage-2 operation -> (4,6,0) held stable for 4 cycles, sequence unchanged, done delayed 3 cycles.
REQ-033 SHALL verify: abort at cycle 8 -> busy=0 from cycle 9, no done; start at cycle 10 -> fresh sequence beginning (0,1,0).
REQ-034 SHALL verify: reset_n=0 at cycle 5 during DRAIN -> all outputs at reset values at the next edge; start pulses at cycles 3 and 19 during busy/DONE are ignored.
REQ-035 SHALL verify: PIPE_LAT=0 -> 12 back-to-back valid cycles 1-12 and done at cycle 13.
